// File: rtl/mips16_alu_pkg.sv
// Shared definitions for the 16-bit ALU and the arbiter that time-shares it:
// ALU mode encodings, arbiter FSM states and the trapped-operation result.
package mips16_alu_pkg;

  localparam logic [3:0] ALU_ZERO = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_NOR  = 4'b0110;
  localparam logic [3:0] ALU_MUL  = 4'b0111;
  localparam logic [3:0] ALU_DIV  = 4'b1000;
  localparam logic [3:0] ALU_MOD  = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1011;
  localparam logic [3:0] ALU_SLT  = 4'b1100;

  // Value returned instead of an ALU result when a divide/modulus by zero is trapped
  localparam logic [15:0] TRAP_RESULT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  // True for the modes that must never see a zero divisor
  function automatic logic isDivMode(input logic [3:0] mode);
    return (mode == ALU_DIV) || (mode == ALU_MOD);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin grant: a lone request wins outright; on a tie the
// requester that was not served last wins.
module rr_pick2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_i,
  output logic grantValid_o,
  output logic grantIdx_o
);

  // Pick the winner from the two valids and the last-served pointer
  always_comb begin
    grantValid_o = valid0_i | valid1_i;
    grantIdx_o   = 1'b0;
    if (valid0_i && valid1_i) begin
      grantIdx_o = ~last_i;
    end else if (valid1_i) begin
      grantIdx_o = 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters. One operation is in flight at a
// time: accept (IDLE), drive the ALU from registered operands (EXEC), then
// hold the captured result for the winner until it is taken (RESP).
module alu_share_arbiter
  import mips16_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MODEW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [MODEW-1:0] req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [MODEW-1:0] req1_mode,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [MODEW-1:0] alu_mode,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero
);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [MODEW-1:0] opMode_q, opMode_d;
  logic             opIdx_q, opIdx_d;
  logic             trap_q, trap_d;
  logic [WIDTH-1:0] rspResult_q, rspResult_d;
  logic             rspZero_q, rspZero_d;
  logic             rspErr_q, rspErr_d;

  logic             grantValid;
  logic             grantIdx;
  logic [WIDTH-1:0] selA;
  logic [WIDTH-1:0] selB;
  logic [MODEW-1:0] selMode;

  rr_pick2 u_pick (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_i       (last_q),
    .grantValid_o (grantValid),
    .grantIdx_o   (grantIdx)
  );

  // Operands of whichever requester currently holds the grant
  always_comb begin
    selA    = grantIdx ? req1_a    : req0_a;
    selB    = grantIdx ? req1_b    : req0_b;
    selMode = grantIdx ? req1_mode : req0_mode;
  end

  // Next-state and handshake/ALU outputs; the ALU sees zeros outside EXEC
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    opA_d       = opA_q;
    opB_d       = opB_q;
    opMode_d    = opMode_q;
    opIdx_d     = opIdx_q;
    trap_d      = trap_q;
    rspResult_d = rspResult_q;
    rspZero_d   = rspZero_q;
    rspErr_d    = rspErr_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_mode    = '0;

    unique case (state_q)
      ST_IDLE: begin
        req0_ready = grantValid & ~grantIdx;
        req1_ready = grantValid & grantIdx;
        if (grantValid) begin
          opA_d    = selA;
          opB_d    = selB;
          opMode_d = selMode;
          opIdx_d  = grantIdx;
          trap_d   = isDivMode(4'(selMode)) && (selB == '0);
          state_d  = ST_EXEC;
        end
      end

      ST_EXEC: begin
        alu_a = opA_q;
        alu_b = opB_q;
        if (trap_q) begin
          rspResult_d = WIDTH'(TRAP_RESULT);
          rspZero_d   = 1'b0;
          rspErr_d    = 1'b1;
        end else begin
          alu_mode    = opMode_q;
          rspResult_d = alu_out;
          rspZero_d   = alu_zero;
          rspErr_d    = 1'b0;
        end
        state_d = ST_RESP;
      end

      ST_RESP: begin
        rsp0_valid = ~opIdx_q;
        rsp1_valid = opIdx_q;
        if (opIdx_q ? rsp1_ready : rsp0_ready) begin
          last_d   = opIdx_q;
          rspErr_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; last starts at 1 so requester 0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      opA_q       <= '0;
      opB_q       <= '0;
      opMode_q    <= '0;
      opIdx_q     <= 1'b0;
      trap_q      <= 1'b0;
      rspResult_q <= '0;
      rspZero_q   <= 1'b0;
      rspErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      opA_q       <= opA_d;
      opB_q       <= opB_d;
      opMode_q    <= opMode_d;
      opIdx_q     <= opIdx_d;
      trap_q      <= trap_d;
      rspResult_q <= rspResult_d;
      rspZero_q   <= rspZero_d;
      rspErr_q    <= rspErr_d;
    end
  end

  assign rsp_result = rspResult_q;
  assign rsp_zero   = rspZero_q;
  assign rsp_err    = rspErr_q;

endmodule
